riscv_dmem_responder: RTL and testbench
=======================================

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning depth of the word-organised data memory (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states between request acceptance and response (0..15).
REQ-003 SHALL have clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have mem_req_i, input, 1 bit: request from the LSU, held high until it sees mem_ready_o.
REQ-006 SHALL have mem_we_i, input, 1 bit: 1 selects write, 0 selects read.
REQ-007 SHALL have mem_be_i, input, 4 bits: per-byte write enables; bit n selects bits [8n+7:8n].
REQ-008 SHALL have mem_addr_i, input, 32 bits: byte address; bits [1:0] ignored.
REQ-009 SHALL have mem_wd_i, input, 32 bits: write data, already byte-replicated by the LSU.
REQ-010 SHALL have mem_rd_o, output, 32 bits: full-word read data, valid only while mem_ready_o is 1.
REQ-011 SHALL have mem_ready_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 IDLE with mem_req_i=1 SHALL latch we, be, word index (addr[log2(MEM_WORDS)+1:2]) and wd, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-014 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
REQ-015 RESP SHALL drive mem_ready_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-016 mem_ready_o SHALL never be 1 in the cycle a request is first sampled, so the minimum request-to-ready latency is 1 cycle and the general latency is WAIT_CYCLES+1 cycles.
REQ-017 A request asserted in the cycle after RESP SHALL be accepted as a new transaction with no bubble.
REQ-018 Read transactions SHALL output mem_rd_o as the latched word read during the RESP cycle; mem_rd_o SHALL be 0 in every cycle outside RESP.
REQ-019 Write transactions SHALL update only the bytes enabled by the latched be, at the RESP clock edge; be=0000 SHALL leave memory unchanged, and mem_rd_o SHALL be 0 during a write RESP.
REQ-020 A read immediately following a write to the same word SHALL return the updated data.
REQ-021 An address with any bit above the index field set SHALL count as out-of-range: reads return 0, writes are dropped, and mem_ready_o still pulses normally.
REQ-022 mem_req_i falling to 0 during WAIT SHALL abort the transaction: no write, no ready pulse, return to IDLE the next cycle.
REQ-023 Input changes after acceptance SHALL be ignored; only the latched values are used.

Reset
REQ-024 rst_ni=0 SHALL immediately force state IDLE, counter 0, mem_ready_o=0 and mem_rd_o=0, including mid-transaction; no pending write is performed.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With RISCV_DMEM_ERR_EN defined, the block SHALL add output mem_err_o (1 bit), which is 1 only in the RESP cycle of an out-of-range access or of a write whose be is not one of 0001/0010/0100/1000/0011/1100/1111; it resets to 0.
REQ-027 With RISCV_DMEM_ERR_EN defined, erroneous writes SHALL be dropped.
REQ-028 Without RISCV_DMEM_ERR_EN, the block SHALL have no mem_err_o port and no error logic; illegal be patterns are written as given.

Structure
REQ-029 The state typedef dmem_state_t (IDLE/WAIT/RESP) and the constant DMEM_MAX_WAIT=15 SHALL live in riscv_pkg.
REQ-030 Storage SHALL be a sub-module riscv_dmem_ram (synchronous byte-enable write, combinational read, MEM_WORDS deep); the FSM, counter and latches stay in the top module.
REQ-031 The counter SHALL be 4 bits wide; WAIT_CYCLES above DMEM_MAX_WAIT SHALL be an elaboration error.

Verification
REQ-032 Latency: WAIT_CYCLES=2, write word 0xDEADBEEF to 0x10 with be=1111 -> mem_ready_o high in exactly cycle 3 after acceptance; a following read of 0x10 returns 0xDEADBEEF with its ready pulse.
REQ-033 Byte lanes: over 0x11223344 at 0x20, write be=0100 with wd 0xAAAAAAAA -> read returns 0x11AA3344; then be=1100 with wd 0x55665566 -> 0x55663344.
REQ-034 Back-to-back: WAIT_CYCLES=0, read, write, read issued with req held continuously -> ready every other cycle, no lost or duplicated transaction.
REQ-035 Abort and reset: drop req in WAIT -> no ready and memory unchanged; pull rst_ni low mid-WAIT on a write -> outputs immediately 0 and the target word unchanged.
REQ-036 Range and error: MEM_WORDS=1024, write to 0x0000_1000 then read it -> read returns 0; with RISCV_DMEM_ERR_EN, mem_err_o=1 on both ready pulses, and be=0110 sets mem_err_o with memory unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and limits for the data-memory responder.
// Holds the FSM state encoding and the wait-state ceiling set by the 4-bit counter.
// With RISCV_DMEM_ERR_EN defined, also provides the legal byte-enable check.
package riscv_pkg;

  // The wait counter is 4 bits wide, so 15 extra cycles is the most it can express.
  localparam int DMEM_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

`ifdef RISCV_DMEM_ERR_EN
  // Naturally aligned byte, halfword and word lanes are the only legal write shapes.
  function automatic logic dmem_be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction
`endif

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// riscv_dmem_responder_if: LSU-to-data-memory request/response bundle.
// Names are from the responder's point of view (_i driven by the LSU, _o by the memory).
// mem_err_o exists only when RISCV_DMEM_ERR_EN is defined.
interface riscv_dmem_responder_if;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wd_i;
  logic [31:0] mem_rd_o;
  logic        mem_ready_o;
`ifdef RISCV_DMEM_ERR_EN
  logic        mem_err_o;
`endif

  modport master (
    output mem_req_i, output mem_we_i, output mem_be_i,
    output mem_addr_i, output mem_wd_i,
    input  mem_rd_o, input mem_ready_o
`ifdef RISCV_DMEM_ERR_EN
    , input mem_err_o
`endif
  );

  modport slave (
    input  mem_req_i, input mem_we_i, input mem_be_i,
    input  mem_addr_i, input mem_wd_i,
    output mem_rd_o, output mem_ready_o
`ifdef RISCV_DMEM_ERR_EN
    , output mem_err_o
`endif
  );

endinterface

// File: rtl/riscv_dmem_ram.sv
// riscv_dmem_ram: MEM_WORDS x 32 storage with per-byte write enables.
// Latency: combinational read, write takes effect at the rising edge with i_we set.
// Backpressure: none; contents are not touched by reset.
module riscv_dmem_ram #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk_i,
  input  logic                         i_we,
  input  logic [3:0]                   i_be,
  input  logic [$clog2(MEM_WORDS)-1:0] i_idx,
  input  logic [31:0]                  i_wd,
  output logic [31:0]                  o_rd
);

  logic [31:0] r_mem [MEM_WORDS];

  // Merge only the enabled byte lanes into the addressed word.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wd[8*b +: 8];
      end
    end
  end

  assign o_rd = r_mem[i_idx];

endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: word-organised data memory slave for the LSU with fixed wait states.
// Latency: WAIT_CYCLES+1 cycles from request acceptance to a one-cycle mem_ready_o pulse.
// Backpressure: LSU holds mem_req_i until ready; dropping it during WAIT aborts the access.
// Optional: define RISCV_DMEM_ERR_EN to add mem_err_o and drop out-of-range/illegal-lane writes.
module riscv_dmem_responder
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  riscv_dmem_responder_if.slave mem
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
    $error("riscv_dmem_responder: WAIT_CYCLES must be 0..%0d", DMEM_MAX_WAIT);
  end
  if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("riscv_dmem_responder: MEM_WORDS must be a power of two >= 4");
  end

  dmem_state_t        r_state;
  dmem_state_t        w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               w_accept;

  logic               r_we;
  logic [3:0]         r_be;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wd;
  logic               r_oor;

  logic               w_oor;
  logic               w_resp;
  logic               w_ram_we;
  logic [31:0]        w_ram_rd;
  logic               w_unused_addr;

  // Any address bit above the index field makes the access out of range.
  assign w_oor         = |mem.mem_addr_i[31:IDX_W+2];
  assign w_unused_addr = ^mem.mem_addr_i[1:0];

  // Next state and counter: accept in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem.mem_req_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = WAIT_CNT;
          w_state_nxt = (WAIT_CNT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!mem.mem_req_i) begin
          // LSU withdrew the request: abandon without touching memory.
          w_cnt_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we  <= 1'b0;
      r_be  <= 4'd0;
      r_idx <= '0;
      r_wd  <= 32'd0;
      r_oor <= 1'b0;
    end else if (w_accept) begin
      r_we  <= mem.mem_we_i;
      r_be  <= mem.mem_be_i;
      r_idx <= mem.mem_addr_i[IDX_W+1:2];
      r_wd  <= mem.mem_wd_i;
      r_oor <= w_oor;
    end
  end

  assign w_resp = (r_state == RESP);

`ifdef RISCV_DMEM_ERR_EN
  logic r_err;

  // Error flag is decided at acceptance so it travels with the latched request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_oor | (mem.mem_we_i & ~dmem_be_legal(mem.mem_be_i));
    end
  end

  assign w_ram_we      = w_resp & r_we & ~r_oor & ~r_err;
  assign mem.mem_err_o = w_resp & r_err;
`else
  assign w_ram_we = w_resp & r_we & ~r_oor;
`endif

  // State is reset asynchronously, so these outputs drop to 0 the moment reset asserts.
  assign mem.mem_ready_o = w_resp;
  assign mem.mem_rd_o    = (w_resp & ~r_we & ~r_oor) ? w_ram_rd : 32'd0;

  riscv_dmem_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk_i (clk_i),
    .i_we  (w_ram_we),
    .i_be  (r_be),
    .i_idx (r_idx),
    .i_wd  (r_wd),
    .o_rd  (w_ram_rd)
  );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: two responders (2 wait states and 0 wait states) on one clock.
// Directed cases cover lanes, range, abort and reset; random traffic is scored against a word-array model.
// Build with RISCV_DMEM_ERR_EN defined to also score mem_err_o and dropped writes.
module tb_riscv_dmem_responder;

  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;        // 0 selects the 2-wait instance, 1 the 0-wait instance
  logic        drv_req;
  logic        drv_we;
  logic [3:0]  drv_be;
  logic [31:0] drv_addr;
  logic [31:0] drv_wd;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] mdl [2][MW];

  always #5 clk = ~clk;

  riscv_dmem_responder_if u_if_w2 ();
  riscv_dmem_responder_if u_if_w0 ();

  assign u_if_w2.mem_req_i  = drv_req & ~sel;
  assign u_if_w2.mem_we_i   = drv_we;
  assign u_if_w2.mem_be_i   = drv_be;
  assign u_if_w2.mem_addr_i = drv_addr;
  assign u_if_w2.mem_wd_i   = drv_wd;
  assign u_if_w0.mem_req_i  = drv_req & sel;
  assign u_if_w0.mem_we_i   = drv_we;
  assign u_if_w0.mem_be_i   = drv_be;
  assign u_if_w0.mem_addr_i = drv_addr;
  assign u_if_w0.mem_wd_i   = drv_wd;

  riscv_dmem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk_i (clk), .rst_ni (rst_n), .mem (u_if_w2)
  );
  riscv_dmem_responder #(.MEM_WORDS(MW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i (clk), .rst_ni (rst_n), .mem (u_if_w0)
  );

  logic        dut_rdy;
  logic [31:0] dut_rd;
  assign dut_rdy = sel ? u_if_w0.mem_ready_o : u_if_w2.mem_ready_o;
  assign dut_rd  = sel ? u_if_w0.mem_rd_o    : u_if_w2.mem_rd_o;
`ifdef RISCV_DMEM_ERR_EN
  logic dut_err;
  assign dut_err = sel ? u_if_w0.mem_err_o : u_if_w2.mem_err_o;

  function automatic bit be_legal(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Mostly in-range words 0..63 (all preloaded); one in eight gets a high address bit set.
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {20'd0, 4'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
    if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
    return a;
  endfunction

  // One transaction on the selected instance; caller is at a falling edge.
  // exp_lat counts falling edges from issue to the ready pulse.
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_lat, input bit keep_req,
                     output logic [31:0] got_rd);
    int          d, wc, lat;
    bit          stray, fresh, oor, drop;
    logic [9:0]  idx;
    logic [31:0] exp_rd;
`ifdef RISCV_DMEM_ERR_EN
    logic        got_err, exp_err;
    got_err = 1'b0;
`endif
    d      = sel ? 1 : 0;
    wc     = sel ? 0 : 2;
    fresh  = (exp_lat == wc + 1);
    drv_we = we; drv_be = be; drv_addr = addr; drv_wd = wd; drv_req = 1'b1;
    lat    = 0; stray = 1'b0; got_rd = 32'd0;
    #1;
    if (fresh && dut_rdy) stray = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dut_rdy) begin
        lat    = k;
        got_rd = dut_rd;
`ifdef RISCV_DMEM_ERR_EN
        got_err = dut_err;
`endif
        break;
      end
      if (dut_rd != 32'd0) stray = 1'b1;
`ifdef RISCV_DMEM_ERR_EN
      if (dut_err) stray = 1'b1;
`endif
      // Request is latched by now: scramble the bus, the DUT must not care.
      if (k == exp_lat - wc) begin
        drv_we = 1'($urandom); drv_be = 4'($urandom); drv_addr = $urandom; drv_wd = $urandom;
      end
    end
    idx  = addr[11:2];
    oor  = (addr[31:12] != 20'd0);
    drop = oor;
`ifdef RISCV_DMEM_ERR_EN
    exp_err = oor || (we && !be_legal(be));
    drop    = drop || exp_err;
    chk("err", 32'(got_err), 32'(exp_err));
`endif
    exp_rd = (we || oor) ? 32'd0 : mdl[d][idx];
    chk("lat", lat, exp_lat);
    chk(we ? "wr_rd" : "rd_data", got_rd, exp_rd);
    chk("quiet", 32'(stray), 32'd0);
    if (we && !drop && lat != 0) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
    if (!keep_req) begin
      drv_req = 1'b0;
      @(negedge clk);
      chk("post_rdy", 32'(dut_rdy), 32'd0);
      chk("post_rd", dut_rd, 32'd0);
    end
  endtask

  // Reset asserted n_neg falling edges after issuing an access on the 2-wait instance.
  task automatic rst_during(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int n_neg, input string tag);
    drv_we = we; drv_be = 4'hf; drv_addr = addr; drv_wd = wd; drv_req = 1'b1;
    repeat (n_neg) @(negedge clk);
    chk({tag, "_pre_rdy"}, 32'(dut_rdy), (n_neg == 3) ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rdy"}, 32'(dut_rdy), 32'd0);
    chk({tag, "_rd"}, dut_rd, 32'd0);
    @(negedge clk);
    drv_req = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    bit          seen;
    rst_n = 1'b0; sel = 1'b0; drv_req = 1'b0; drv_we = 1'b0;
    drv_be = 4'd0; drv_addr = 32'd0; drv_wd = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdy_w2", 32'(u_if_w2.mem_ready_o), 32'd0);
    chk("rst_rd_w2", u_if_w2.mem_rd_o, 32'd0);
    chk("rst_rdy_w0", 32'(u_if_w0.mem_ready_o), 32'd0);
    chk("rst_rd_w0", u_if_w0.mem_rd_o, 32'd0);
`ifdef RISCV_DMEM_ERR_EN
    chk("rst_err_w2", 32'(u_if_w2.mem_err_o), 32'd0);
    chk("rst_err_w0", 32'(u_if_w0.mem_err_o), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Preload words 0..63 of both instances with known data.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 64; i++) txn(1'b1, 4'hf, 32'(i * 4), $urandom, (s == 0) ? 3 : 1, 1'b0, r);
    end

    // Latency and read-back on the 2-wait instance.
    sel = 1'b0;
    txn(1'b1, 4'hf, 32'h10, 32'hDEADBEEF, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h10, 32'h0, 3, 1'b0, r);
    chk("rd_deadbeef", r, 32'hDEADBEEF);

    // Byte lanes.
    txn(1'b1, 4'hf, 32'h20, 32'h11223344, 3, 1'b0, r);
    txn(1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h20, 32'h0, 3, 1'b0, r);
    chk("lane_0100", r, 32'h11AA3344);
    txn(1'b1, 4'b1100, 32'h20, 32'h55665566, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h20, 32'h0, 3, 1'b0, r);
    chk("lane_1100", r, 32'h55663344);
    txn(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h20, 32'h0, 3, 1'b0, r);
    chk("lane_0000", r, 32'h55663344);

    // Illegal lane shape: dropped with the error option, written as given otherwise.
    txn(1'b1, 4'b0110, 32'h10, 32'h12345678, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h10, 32'h0, 3, 1'b0, r);
`ifdef RISCV_DMEM_ERR_EN
    chk("be0110_drop", r, 32'hDEADBEEF);
`else
    chk("be0110_wr", r, 32'hDE3456EF);
`endif

    // Out of range: 0x1000 would alias word 0 if the high bit were ignored.
    txn(1'b1, 4'hf, 32'h1000, 32'hCAFEF00D, 3, 1'b0, r);
    txn(1'b0, 4'hf, 32'h1000, 32'h0, 3, 1'b0, r);
    chk("oor_rd", r, 32'd0);
    txn(1'b0, 4'hf, 32'h0, 32'h0, 3, 1'b0, r);

    // Abort: drop req one cycle into WAIT.
    drv_we = 1'b1; drv_be = 4'hf; drv_addr = 32'h1C; drv_wd = ~mdl[0][7]; drv_req = 1'b1;
    @(negedge clk);
    drv_req = 1'b0;
    seen    = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dut_rdy) seen = 1'b1;
    end
    chk("abort_rdy", 32'(seen), 32'd0);
    txn(1'b0, 4'hf, 32'h1C, 32'h0, 3, 1'b0, r);

    // Reset mid-WAIT on a write, then during a write RESP and a read RESP.
    rst_during(1'b1, 32'h24, ~mdl[0][9], 1, "rst_wait_wr");
    txn(1'b0, 4'hf, 32'h24, 32'h0, 3, 1'b0, r);
    rst_during(1'b1, 32'h28, ~mdl[0][10], 3, "rst_resp_wr");
    txn(1'b0, 4'hf, 32'h28, 32'h0, 3, 1'b0, r);
    rst_during(1'b0, 32'h20, 32'h0, 3, "rst_resp_rd");
    txn(1'b0, 4'hf, 32'h20, 32'h0, 3, 1'b0, r);
    chk("mem_kept", r, 32'h55663344);

    // Back-to-back read, write, read with req held on the 0-wait instance.
    sel = 1'b1;
    w   = $urandom;
    txn(1'b0, 4'hf, 32'h30, 32'h0, 1, 1'b1, r);
    txn(1'b1, 4'hf, 32'h30, w, 2, 1'b1, r);
    txn(1'b0, 4'hf, 32'h30, 32'h0, 2, 1'b0, r);
    chk("b2b_raw", r, w);

    // Random traffic on both instances, mixing idle gaps and back-to-back issue.
    for (int s = 0; s < 2; s++) begin
      bit prev_keep;
      sel       = s[0];
      prev_keep = 1'b0;
      for (int n = 0; n < 150; n++) begin
        bit keep;
        keep = (n != 149) && ($urandom_range(0, 2) == 0);
        txn(1'($urandom), 4'($urandom), rnd_addr(), $urandom,
            ((s == 0) ? 3 : 1) + (prev_keep ? 1 : 0), keep, r);
        prev_keep = keep;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
